// File: rtl/flasher_seq_ctrl.sv
// LED bar sequencer: walks a bar level through a programmable table of waypoints
// at a prescaled rate. The flick button starts a run or kicks a descent back up.
module flasher_seq_ctrl #(
  parameter int LED_W = 16,
  parameter int LVL_W = 5,
  parameter int NSEG  = 8,
  parameter int IDX_W = 3,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flick,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_addr,
  input  logic [LVL_W-1:0] cfg_data,
  input  logic [IDX_W:0]   cfg_len,
  input  logic [DIV_W-1:0] div,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] seg_idx,
  output logic [LVL_W-1:0] level,
  output logic [LED_W-1:0] LED
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic             dir_up;
  logic             flick_q;
  logic [DIV_W-1:0] presc;
  logic [IDX_W:0]   len_r;
  logic [LVL_W-1:0] wp [NSEG];

  logic             fe;
  logic             tick;
  logic             kick;
  logic             last_seg;
  logic             reached;
  logic [LVL_W-1:0] tgt;
  logic [LVL_W-1:0] nxt_tgt;
  logic [LVL_W-1:0] step_lvl;
  logic [LVL_W-1:0] level_n;

  function automatic logic [LVL_W-1:0] wp_default(input int i);
    case (i)
      0:       wp_default = LVL_W'(16);
      1:       wp_default = LVL_W'(6);
      2:       wp_default = LVL_W'(11);
      4:       wp_default = LVL_W'(6);
      default: wp_default = '0;
    endcase
  endfunction

  function automatic logic [LVL_W-1:0] clamp_lvl(input logic [LVL_W-1:0] d);
    if (d > LVL_W'(LED_W)) return LVL_W'(LED_W);
    return d;
  endfunction

  function automatic logic [IDX_W:0] clamp_len(input logic [IDX_W:0] n);
    if (n == '0) return (IDX_W+1)'(1);
    if (n > (IDX_W+1)'(NSEG)) return (IDX_W+1)'(NSEG);
    return n;
  endfunction

  // Shifting all-ones by the level leaves exactly `level` low bits clear; a
  // full-scale level shifts everything out and yields an all-ones image.
  function automatic logic [LED_W-1:0] therm(input logic [LVL_W-1:0] lvl);
    return ~({LED_W{1'b1}} << lvl);
  endfunction

  always_comb begin
    fe       = flick & ~flick_q;
    tick     = (state == RUN) && (presc == div);
    tgt      = wp[seg_idx];
    nxt_tgt  = wp[seg_idx + IDX_W'(1)];
    last_seg = ({1'b0, seg_idx} == (len_r - (IDX_W+1)'(1)));
    kick     = (state == RUN) && fe && !dir_up && !last_seg && (seg_idx != '0);

    step_lvl = level;
    if (level != tgt) begin
      if (dir_up) step_lvl = level + LVL_W'(1);
      else        step_lvl = level - LVL_W'(1);
    end
    reached = (step_lvl == tgt);

    // Next level drives both the level register and its LED image so they align.
    level_n = level;
    if (state == IDLE) begin
      level_n = '0;
    end else if (tick && !kick) begin
      level_n = (reached && last_seg) ? '0 : step_lvl;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      dir_up  <= 1'b1;
      flick_q <= 1'b0;
      presc   <= '0;
      len_r   <= (IDX_W+1)'(1);
      seg_idx <= '0;
      level   <= '0;
      LED     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      for (int i = 0; i < NSEG; i++) wp[i] <= wp_default(i);
    end else begin
      flick_q <= flick;
      done    <= 1'b0;
      level   <= level_n;
      LED     <= therm(level_n);
      case (state)
        IDLE: begin
          if (cfg_we) wp[cfg_addr] <= clamp_lvl(cfg_data);
          if (fe) begin
            state   <= RUN;
            busy    <= 1'b1;
            seg_idx <= '0;
            presc   <= '0;
            dir_up  <= 1'b1;
            len_r   <= clamp_len(cfg_len);
          end
        end
        RUN: begin
          if (kick) begin
            seg_idx <= seg_idx - IDX_W'(1);
            dir_up  <= 1'b1;
            presc   <= '0;
          end else begin
            presc <= tick ? '0 : presc + DIV_W'(1);
            if (tick && reached) begin
              if (last_seg) begin
                state   <= IDLE;
                busy    <= 1'b0;
                done    <= 1'b1;
                seg_idx <= '0;
              end else begin
                seg_idx <= seg_idx + IDX_W'(1);
                dir_up  <= (nxt_tgt >= step_lvl);
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flasher_seq_ctrl.sv
// Directed bench for flasher_seq_ctrl: runs, prescaling, kicks, config and reset.
module tb_flasher_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       flick;
  logic       cfg_we;
  logic [2:0] cfg_addr;
  logic [4:0] cfg_data;
  logic [3:0] cfg_len;
  logic [7:0] div;
  logic       busy;
  logic       done;
  logic [2:0] seg_idx;
  logic [4:0] level;
  logic [15:0] LED;

  int checks = 0;
  int errors = 0;
  int tg [8];

  flasher_seq_ctrl dut (
    .clk(clk), .reset(reset), .flick(flick), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_len(cfg_len), .div(div), .busy(busy), .done(done),
    .seg_idx(seg_idx), .level(level), .LED(LED)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Pulse flick at the current negedge, then follow the run cycle by cycle
  // against a trajectory built from the waypoint list tg[0..nt-1].
  task automatic run_follow(input int d, input int nt, input bit busy_wr);
    int traj[$];
    int lvl;
    int n;
    int k;
    int nticks;
    traj.delete();
    lvl = 0;
    traj.push_back(0);
    for (int s = 0; s < nt; s++) begin
      if (lvl == tg[s]) traj.push_back(lvl);
      else while (lvl != tg[s]) begin
        lvl += (tg[s] > lvl) ? 1 : -1;
        traj.push_back(lvl);
      end
    end
    nticks = traj.size() - 1;
    div = 8'(d);
    flick = 1'b1;
    @(negedge clk);
    flick = 1'b0;
    k = 1;
    forever begin
      n = (k - 1) / (d + 1);
      if (n < nticks) begin
        chk("run_level", 32'(level), 32'(traj[n]));
        chk("run_led", 32'(LED), 32'(((32'd1 << traj[n]) - 32'd1) & 32'hFFFF));
        chk("run_busy", 32'(busy), 32'd1);
        chk("run_done", 32'(done), 32'd0);
      end else begin
        chk("end_level", 32'(level), 32'd0);
        chk("end_led", 32'(LED), 32'd0);
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_done", 32'(done), 32'd1);
        break;
      end
      if (busy_wr && k == 3) begin
        cfg_we = 1'b1; cfg_addr = 3'd1; cfg_data = 5'd9;
      end else begin
        cfg_we = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    cfg_we = 1'b0;
    @(negedge clk);
    chk("post_done", 32'(done), 32'd0);
    chk("post_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int dcnt;
    reset = 1'b1; flick = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    cfg_len = 4'd6; div = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_led", 32'(LED), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_seg", 32'(seg_idx), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Default table, one step per cycle, then every 4th cycle.
    tg = '{16, 6, 11, 0, 6, 0, 0, 0};
    run_follow(0, 6, 1'b0);
    run_follow(3, 6, 1'b0);

    // Kick on the first descent, ignored kick on the final descent.
    div = 8'd0; cfg_len = 4'd6; flick = 1'b1;
    for (int k = 1; k <= 69; k++) begin
      @(negedge clk);
      flick = 1'b0;
      if (k == 23) begin
        chk("kick_pre_level", 32'(level), 32'd10);
        chk("kick_pre_seg", 32'(seg_idx), 32'd1);
        flick = 1'b1;
      end
      if (k == 24) begin
        chk("kick_level_hold", 32'(level), 32'd10);
        chk("kick_seg", 32'(seg_idx), 32'd0);
      end
      if (k == 25) chk("kick_climb", 32'(level), 32'd11);
      if (k == 30) begin
        chk("kick_peak", 32'(level), 32'd16);
        chk("kick_peak_led", 32'(LED), 32'hFFFF);
        chk("kick_peak_seg", 32'(seg_idx), 32'd1);
      end
      if (k == 31) chk("kick_redescend", 32'(level), 32'd15);
      if (k == 64) begin
        chk("last_pre_level", 32'(level), 32'd4);
        flick = 1'b1;
      end
      if (k == 65) begin
        chk("last_kick_level", 32'(level), 32'd3);
        chk("last_kick_seg", 32'(seg_idx), 32'd5);
        chk("last_kick_busy", 32'(busy), 32'd1);
      end
      if (k == 68) begin
        chk("kick_run_done", 32'(done), 32'd1);
        chk("kick_run_level", 32'(level), 32'd0);
        chk("kick_run_busy", 32'(busy), 32'd0);
      end
      if (k == 69) chk("kick_run_done_clr", 32'(done), 32'd0);
    end

    // Length above table depth clamps to 8; trailing equal waypoints cost a tick each.
    cfg_len = 4'd15;
    run_follow(0, 8, 1'b0);

    // Configure in IDLE: 20 clamps to 16.
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 5'd20;
    @(negedge clk);
    cfg_addr = 3'd1; cfg_data = 5'd3;
    @(negedge clk);
    cfg_we = 1'b0; cfg_len = 4'd2;
    @(negedge clk);
    tg = '{16, 3, 11, 0, 6, 0, 0, 0};
    run_follow(0, 2, 1'b1);
    run_follow(0, 2, 1'b0);

    // Held button: a single run, nothing on hold or release.
    flick = 1'b1; dcnt = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (done) dcnt++;
      if (k == 2) chk("hold_busy_on", 32'(busy), 32'd1);
      if (k == 60) chk("hold_busy_off", 32'(busy), 32'd0);
    end
    chk("hold_done_count", 32'(dcnt), 32'd1);
    flick = 1'b0;
    repeat (5) @(negedge clk);
    chk("release_busy", 32'(busy), 32'd0);
    chk("release_level", 32'(level), 32'd0);

    // Length 0 is treated as 1.
    cfg_len = 4'd0;
    run_follow(0, 1, 1'b0);

    // Reset mid-run restores idle outputs and default table.
    cfg_len = 4'd6; div = 8'd0; flick = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      flick = 1'b0;
    end
    chk("mid_level", 32'(level), 32'd9);
    reset = 1'b1;
    @(negedge clk);
    chk("mrst_level", 32'(level), 32'd0);
    chk("mrst_led", 32'(LED), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    tg = '{16, 6, 11, 0, 6, 0, 0, 0};
    run_follow(0, 6, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
